// File: rtl/share_loader_if.sv
// Word-stream and parallel-share bus between the control-FPGA interface, the share
// loader and the masked Keccak DUT.
interface share_loader_if #(
    parameter int WORD_W = 32,
    parameter int DIN_W  = 3200
);
    logic [WORD_W-1:0] word_i;
    logic              word_vld_i;
    logic              word_rdy_o;
    logic              flush_i;
    logic              dout_vld_i;
    logic [DIN_W-1:0]  din_o;
    logic              din_vld_o;

    modport slave (
        input  word_i, word_vld_i, flush_i, dout_vld_i,
        output word_rdy_o, din_o, din_vld_o
    );

    modport master (
        output word_i, word_vld_i, flush_i, dout_vld_i,
        input  word_rdy_o, din_o, din_vld_o
    );
endinterface

// File: rtl/share_loader.sv
// Assembles the serial word stream into both Keccak input shares and fires a
// one-cycle start pulse to the DUT, then holds off until the DUT reports a result.
module share_loader #(
    parameter int WORD_W  = 32,
    parameter int SHARE_W = 1600,
    parameter int NSHARES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    share_loader_if.slave bus
);
    localparam int DIN_W  = NSHARES * SHARE_W;
    localparam int NWORDS = DIN_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    if ((DIN_W % WORD_W) != 0) begin : g_bad_word_w
        $error("share_loader: NSHARES*SHARE_W must be a multiple of WORD_W");
    end

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                         state_r;
    state_t                         next_state_s;
    logic [CNT_W-1:0]               cnt_r;
    logic [CNT_W-1:0]               cnt_nxt_s;
    logic [NWORDS-1:0][WORD_W-1:0]  din_r;
    logic                           word_rdy_s;
    logic                           din_vld_s;
    logic                           accept_s;

    assign accept_s = bus.word_vld_i & word_rdy_s;

    // State and word counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
            cnt_r   <= '0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Share assembly: the slot addressed by the counter captures the accepted word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_r <= '0;
        end else begin
            for (int w = 0; w < NWORDS; w++) begin
                if (accept_s && (cnt_r == CNT_W'(w))) begin
                    din_r[w] <= bus.word_i;
                end
            end
        end
    end

    // Next-state and counter logic; flush overrides every other transition
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        if (bus.flush_i) begin
            next_state_s = ST_LOAD;
            cnt_nxt_s    = '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        if (cnt_r == CNT_W'(NWORDS - 1)) begin
                            next_state_s = ST_FIRE;
                            cnt_nxt_s    = '0;
                        end else begin
                            cnt_nxt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_FIRE: begin
                    next_state_s = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.dout_vld_i) begin
                        next_state_s = ST_LOAD;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                default: begin
                    next_state_s = ST_LOAD;
                    cnt_nxt_s    = '0;
                end
            endcase
        end
    end

    // Outputs decoded from state; ready is held low during reset and flush
    always_comb begin
        word_rdy_s = 1'b0;
        din_vld_s  = 1'b0;
        case (state_r)
            ST_LOAD: word_rdy_s = rst_n & ~bus.flush_i;
            ST_FIRE: din_vld_s  = 1'b1;
            ST_WAIT: din_vld_s  = 1'b0;
            default: begin
                word_rdy_s = 1'b0;
                din_vld_s  = 1'b0;
            end
        endcase
    end

    assign bus.word_rdy_o = word_rdy_s;
    assign bus.din_vld_o  = din_vld_s;
    assign bus.din_o      = din_r;

endmodule

// File: tb/tb_share_loader.sv
// Randomized bench for share_loader: drives word loads with interleaved
// re-arm, flush and reset events and compares against an event-level model.
module tb_share_loader;
    localparam int WORD_W = 32;
    localparam int NWORDS = 100;
    localparam int DIN_W  = 3200;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    share_loader_if #(.WORD_W(WORD_W), .DIN_W(DIN_W)) bus ();

    share_loader #(.WORD_W(32), .SHARE_W(1600), .NSHARES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    // Reference model: words taken so far, pulse-in-progress, and blocked-until-result
    int               m_cnt   = 0;
    bit               m_fire  = 1'b0;
    bit               m_wait  = 1'b0;
    logic [DIN_W-1:0] m_din   = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit vld, input logic [31:0] w, input bit fl, input bit dv, input bit rstv);
        bit exp_rdy;
        bit acc;
        int k;
        bus.word_vld_i = vld;
        bus.word_i     = w;
        bus.flush_i    = fl;
        bus.dout_vld_i = dv;
        rst_n          = rstv;
        #1;
        exp_rdy = rstv && !fl && !m_fire && !m_wait;
        check_eq("word_rdy", 64'(bus.word_rdy_o), 64'(exp_rdy));
        acc = vld && exp_rdy;
        @(posedge clk);
        if (!rstv) begin
            m_cnt = 0; m_fire = 1'b0; m_wait = 1'b0; m_din = '0;
        end else if (fl) begin
            m_cnt = 0; m_fire = 1'b0; m_wait = 1'b0;
        end else if (m_fire) begin
            m_fire = 1'b0; m_wait = 1'b1;
        end else if (m_wait) begin
            if (dv) m_wait = 1'b0;
        end else if (acc) begin
            m_din[m_cnt*WORD_W +: WORD_W] = w;
            m_cnt++;
            if (m_cnt == NWORDS) begin
                m_cnt  = 0;
                m_fire = 1'b1;
            end
        end
        #1;
        check_eq("din_vld", 64'(bus.din_vld_o), 64'(m_fire));
        if (bus.din_vld_o === 1'b1) pulses++;
        k = 0;
        for (int i = 0; i < NWORDS; i++) begin
            if (bus.din_o[i*WORD_W +: WORD_W] !== m_din[i*WORD_W +: WORD_W]) begin
                k = i;
                break;
            end
        end
        check_eq($sformatf("din_w%0d", k), 64'(bus.din_o[k*WORD_W +: WORD_W]),
                 64'(m_din[k*WORD_W +: WORD_W]));
        @(negedge clk);
    endtask

    task automatic run_load(input string name, input bit rnd, input bit kdata,
                            input int dv_at, input int fl_at, input int rst_at);
        int          guard;
        bit          dv_used, fl_used, rst_used;
        bit          vld, fl, dv, rv;
        logic [31:0] w;
        guard = 0; dv_used = 1'b0; fl_used = 1'b0; rst_used = 1'b0;
        pulses = 0;
        while (!m_fire && guard < 3000) begin
            vld = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            w   = kdata ? 32'(m_cnt) : 32'($urandom);
            dv = 1'b0; fl = 1'b0; rv = 1'b1;
            if (!dv_used && m_cnt == dv_at) begin dv = 1'b1; dv_used = 1'b1; end
            if (!fl_used && m_cnt == fl_at) begin fl = 1'b1; vld = 1'b1; fl_used = 1'b1; end
            if (!rst_used && m_cnt == rst_at) begin rv = 1'b0; rst_used = 1'b1; end
            cycle(vld, w, fl, dv, rv);
            guard++;
        end
        check_eq({name, "_pulses"}, 64'(pulses), 64'd1);
    endtask

    task automatic rearm();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic check_t1_words(input string name);
        check_eq({name, "_w0"},  64'(bus.din_o[31:0]),      64'd0);
        check_eq({name, "_w50"}, 64'(bus.din_o[1631:1600]), 64'd50);
        check_eq({name, "_w99"}, 64'(bus.din_o[3199:3168]), 64'd99);
    endtask

    initial begin
        bus.word_vld_i = 1'b0;
        bus.word_i     = 32'h0;
        bus.flush_i    = 1'b0;
        bus.dout_vld_i = 1'b0;
        rst_n          = 1'b0;
        @(negedge clk);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // T1: back-to-back words 0..99
        run_load("t1", 1'b0, 1'b1, -1, -1, -1);
        check_t1_words("t1");

        // T3: held-off traffic after the pulse, then re-arm; T4: stray result at word 30
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        run_load("t4", 1'b1, 1'b0, 30, -1, -1);
        rearm();

        // T2: ~50% valid duty, same data as T1; then flush during the pulse cycle
        run_load("t2", 1'b1, 1'b1, -1, -1, -1);
        check_t1_words("t2");
        cycle(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1);

        // T5: flush at word 40, load restarts from word 0
        run_load("t5", 1'b1, 1'b0, -1, 40, -1);
        rearm();

        // T6: reset at word 60, then a full fresh load
        run_load("t6", 1'b0, 1'b1, -1, -1, 60);
        check_t1_words("t6");
        rearm();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
